dram_loader: RTL and testbench
==============================

# dram_loader

Diagnostic loader and readback engine for the 512×15 IR dispatch RAM (DRAM). It decodes diagnostic function strobes from the EBUS/CTL path, stages A, B and J fields, and generates odd parity. It drives the DRAM write port with auto-incrementing addresses and reads words back with a parity check. It sits directly upstream of the IR stage's DRAM and owns that RAM's `addr`, `din` and `we` inputs.

## Interface
- `ADDR_BITS`, 9: DRAM address width (512 words).
- `WIDTH`, 15: DRAM word width; packing is {A[0:2], B[0:2], P, J[1:4], J[7:10]}.

Ports:
- `clk` in 1: the single clock (the IR clock).
- `reset` in 1: asynchronous, active-high reset.
- `diag_strobe` in 1: one-cycle function strobe.
- `diag_func` in 7: diagnostic function code, valid with the strobe.
- `diag_data` in 36: EBUS data [0:35], PDP-10 bit order.
- `busy` out 1: the engine is executing a WRITE or READ.
- `dram_addr` out 9: DRAM address.
- `dram_din` out 15: DRAM write data.
- `dram_we` out 1: DRAM write enable.
- `dram_en` out 1: DRAM access enable.
- `dram_dout` in 15: DRAM read data, one-cycle synchronous latency.
- `rd_data` out 15: last word read back.
- `rd_valid` out 1: one-cycle pulse when `rd_data` updates.
- `par_err` out 1: sticky flag; a readback word had even parity.
- `overrun` out 1: sticky flag; a strobe arrived while `busy` was high.

## Operation
- Function codes (octal) are acted on only when `diag_strobe` is high and `busy` is low:
  - 050 LOAD_ADDR: address counter <= data[27:35].
  - 051 LOAD_AB: stage A <= data[30:32] and B <= data[33:35].
  - 052 LOAD_J: stage Jhi <= data[28:31] and Jlo <= data[32:35].
  - 053 WRITE: enter state WRITE.
  - 054 READ: enter state RD_ISSUE.
  - 055 CLEAR: `par_err` <= 0 and `overrun` <= 0.
- All other codes are ignored with no state change.
- Parity: P = ~^{A, B, Jhi, Jlo}, so the XOR of all 15 stored bits is 1.
- FSM states:
  - IDLE: `busy` = 0.
  - WRITE: `dram_en` = `dram_we` = 1. `dram_din` = {A, B, P, Jhi, Jlo}. `dram_addr` = address counter. Next state is IDLE; the address counter increments.
  - RD_ISSUE: `dram_en` = 1, `dram_we` = 0. Next state is RD_CAP.
  - RD_CAP: `rd_data` <= `dram_dout` and `rd_valid` pulses. `par_err` |= ~^`dram_dout`. The address counter increments. Next state is IDLE.
- The address counter is 9 bits and wraps from 511 to 0. Staging registers persist across writes, so repeated WRITEs with no new LOADs fill consecutive words with the same data.
- A strobe while `busy` = 1 is dropped and sets `overrun`, regardless of function code.
- Reset, including mid-operation: FSM goes to IDLE. The following are cleared to 0: address counter, staging A/B/J, `rd_data`, `rd_valid`, `par_err`, `overrun`, `dram_we`, `dram_en`, `dram_addr`, `dram_din`, `busy`. An aborted WRITE performs no write. An aborted READ produces no `rd_valid`.

## Timing
- All outputs are registered.
- LOAD_ADDR, LOAD_AB, LOAD_J and CLEAR: the strobe in cycle 0 takes effect in cycle 1.
- WRITE: strobe in cycle 0. In cycle 1, `busy` = `dram_we` = `dram_en` = 1, and the RAM captures the word at the edge ending cycle 1. In cycle 2, `busy` = 0 and the address counter is +1.
- READ: strobe in cycle 0.
  - Cycle 1 (RD_ISSUE): `busy` = 1 and `dram_en` = 1.
  - Cycle 2 (RD_CAP): `busy` = 1 and `dram_dout` is valid.
  - Cycle 3: `rd_valid` = 1, `rd_data` is updated and `par_err` is updated.
- A new strobe is accepted in the first cycle with `busy` = 0: cycle 2 after a WRITE, cycle 3 after a READ.
- `dram_we` is never asserted outside state WRITE. `dram_din` holds its last value when not writing.

## Test plan
- Reset check: assert `reset` asynchronously mid-cycle. All outputs go to 0 immediately; there is no `dram_we` glitch.
- Single write and readback: LOAD_ADDR 0o254, LOAD_AB data[30:35] = 0o35, LOAD_J data[28:35] = 0o247, WRITE, then LOAD_ADDR 0o254 and READ. Required: `rd_data` = {3'o3, 3'o5, P, 4'b1010, 4'b0111} with odd total parity, `rd_valid` in cycle 3 after the READ strobe, and `par_err` = 0.
- Wraparound: LOAD_ADDR 511, then WRITE twice. Required: the writes hit addresses 511 then 0, and the counter ends at 1.
- Overrun: issue READ, then any strobe in the next cycle. Required: the second strobe is ignored, `overrun` = 1, and CLEAR returns it to 0.
- Parity error: a model RAM returns 15'h0000 on a read. Required: `par_err` = 1, and it stays 1 across a subsequent good read.
- Reset mid-WRITE: assert `reset` in cycle 1 of a WRITE. Required: the RAM location is unchanged and the FSM is IDLE.

Source files
------------

// File: rtl/dram_loader_if.sv
// dram_loader_if: diagnostic strobe bus plus DRAM port of the loader
interface dram_loader_if #(
    parameter int ADDR_BITS = 9,
    parameter int WIDTH = 15
);
    logic                 diag_strobe;
    logic [6:0]           diag_func;
    logic [35:0]          diag_data;
    logic                 busy;
    logic [ADDR_BITS-1:0] dram_addr;
    logic [WIDTH-1:0]     dram_din;
    logic                 dram_we;
    logic                 dram_en;
    logic [WIDTH-1:0]     dram_dout;
    logic [WIDTH-1:0]     rd_data;
    logic                 rd_valid;
    logic                 par_err;
    logic                 overrun;
    modport master (
        output diag_strobe, diag_func, diag_data, dram_dout,
        input  busy, dram_addr, dram_din, dram_we, dram_en, rd_data, rd_valid, par_err, overrun
    );
    modport slave (
        input  diag_strobe, diag_func, diag_data, dram_dout,
        output busy, dram_addr, dram_din, dram_we, dram_en, rd_data, rd_valid, par_err, overrun
    );
endinterface

// File: rtl/dram_loader.sv
// dram_loader: diagnostic load, write and parity-checked readback engine for the IR dispatch RAM
module dram_loader #(
    parameter int ADDR_BITS = 9,
    parameter int WIDTH = 15
) (
    input logic clk,
    input logic reset,
    dram_loader_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WRITE, RD_ISSUE, RD_CAP} state_t;
    state_t state;
    logic [ADDR_BITS-1:0] addr;
    logic [2:0] a, b;
    logic [3:0] jhi, jlo;
    logic [WIDTH-1:0] word;
    assign word = {a, b, ~^{a, b, jhi, jlo}, jhi, jlo};
    // the address counter itself is the registered DRAM address
    assign bus.dram_addr = addr;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            addr         <= '0;
            a            <= '0;
            b            <= '0;
            jhi          <= '0;
            jlo          <= '0;
            bus.busy     <= 1'b0;
            bus.dram_din <= '0;
            bus.dram_we  <= 1'b0;
            bus.dram_en  <= 1'b0;
            bus.rd_data  <= '0;
            bus.rd_valid <= 1'b0;
            bus.par_err  <= 1'b0;
            bus.overrun  <= 1'b0;
        end else begin
            bus.rd_valid <= 1'b0;
            if (bus.diag_strobe && bus.busy) bus.overrun <= 1'b1;
            case (state)
                IDLE: if (bus.diag_strobe) begin
                    case (bus.diag_func)
                        7'o50: addr <= bus.diag_data[ADDR_BITS-1:0];
                        7'o51: {a, b} <= bus.diag_data[5:0];
                        7'o52: {jhi, jlo} <= bus.diag_data[7:0];
                        7'o53: begin
                            state        <= WRITE;
                            bus.busy     <= 1'b1;
                            bus.dram_en  <= 1'b1;
                            bus.dram_we  <= 1'b1;
                            bus.dram_din <= word;
                        end
                        7'o54: begin
                            state       <= RD_ISSUE;
                            bus.busy    <= 1'b1;
                            bus.dram_en <= 1'b1;
                        end
                        7'o55: begin
                            bus.par_err <= 1'b0;
                            bus.overrun <= 1'b0;
                        end
                        default: ;
                    endcase
                end
                WRITE: begin
                    state       <= IDLE;
                    bus.busy    <= 1'b0;
                    bus.dram_en <= 1'b0;
                    bus.dram_we <= 1'b0;
                    addr        <= addr + 1'b1;
                end
                RD_ISSUE: begin
                    state       <= RD_CAP;
                    bus.dram_en <= 1'b0;
                end
                RD_CAP: begin
                    state        <= IDLE;
                    bus.busy     <= 1'b0;
                    bus.rd_data  <= bus.dram_dout;
                    bus.rd_valid <= 1'b1;
                    bus.par_err  <= bus.par_err | ~^bus.dram_dout;
                    addr         <= addr + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dram_loader.sv
// tb_dram_loader: directed stimulus with a cycle-timed behavioural model and literal spot checks
module tb_dram_loader;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dram_loader_if dif();
    dram_loader dut (.clk(clk), .reset(reset), .bus(dif));

    int total = 0;
    int bad = 0;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, act, exp);
        end
    endtask

    // environment RAM: 512x15, one-cycle read latency, optional forced all-zero reads
    logic [14:0] ram [512] = '{default: 15'h7FFF};
    logic ram_bad = 1'b0;
    int wr_log[$];
    always @(posedge clk) begin
        if (dif.dram_en) begin
            if (dif.dram_we) begin
                ram[dif.dram_addr] <= dif.dram_din;
                wr_log.push_back(int'(dif.dram_addr));
            end else begin
                dif.dram_dout <= ram_bad ? 15'h0 : ram[dif.dram_addr];
            end
        end
    end

    // model: op kind (0 none, 1 write, 2 read) and the cycle its strobe was accepted
    logic [14:0] mem_e [512] = '{default: 15'h7FFF};
    int cyc = 0;
    int op = 0;
    int op_c = 0;
    logic [8:0] addr_e = '0;
    logic [2:0] a_e = '0, b_e = '0;
    logic [3:0] jh_e = '0, jl_e = '0;
    logic [14:0] din_e = '0, rd_e = '0;
    logic par_e = 1'b0, ovr_e = 1'b0, bsy_e, p_e;

    always @(negedge clk) begin
        if (reset) begin
            op = 0; addr_e = '0; a_e = '0; b_e = '0; jh_e = '0; jl_e = '0;
            din_e = '0; rd_e = '0; par_e = 1'b0; ovr_e = 1'b0;
        end else begin
            bsy_e = (op == 1 && cyc == op_c + 1) || (op == 2 && cyc >= op_c + 1 && cyc <= op_c + 2);
            chk("busy", dif.busy, bsy_e);
            chk("dram_we", dif.dram_we, op == 1 && cyc == op_c + 1);
            chk("dram_en", dif.dram_en, op != 0 && cyc == op_c + 1);
            chk("rd_valid", dif.rd_valid, op == 2 && cyc == op_c + 3);
            chk("rd_data", dif.rd_data, rd_e);
            chk("par_err", dif.par_err, par_e);
            chk("overrun", dif.overrun, ovr_e);
            chk("dram_din", dif.dram_din, din_e);
            if (op != 0 && cyc == op_c + 1) chk("dram_addr", dif.dram_addr, addr_e);
            if (op == 1 && cyc == op_c + 1) begin
                mem_e[addr_e] = din_e;
                addr_e = addr_e + 9'd1;
            end
            if (op == 2 && cyc == op_c + 2) begin
                rd_e = ram_bad ? 15'h0 : mem_e[addr_e];
                if ($countones(rd_e) % 2 == 0) par_e = 1'b1;
                addr_e = addr_e + 9'd1;
            end
            if (dif.diag_strobe) begin
                if (bsy_e) ovr_e = 1'b1;
                else case (dif.diag_func)
                    7'o50: addr_e = dif.diag_data[8:0];
                    7'o51: begin a_e = dif.diag_data[5:3]; b_e = dif.diag_data[2:0]; end
                    7'o52: begin jh_e = dif.diag_data[7:4]; jl_e = dif.diag_data[3:0]; end
                    7'o53: begin
                        p_e = ($countones({a_e, b_e, jh_e, jl_e}) % 2 == 0);
                        din_e = {a_e, b_e, p_e, jh_e, jl_e};
                        op = 1; op_c = cyc;
                    end
                    7'o54: begin op = 2; op_c = cyc; end
                    7'o55: begin par_e = 1'b0; ovr_e = 1'b0; end
                    default: ;
                endcase
            end
        end
        cyc++;
    end

    // tasks start and end at posedge+1
    task automatic str(input logic [6:0] f, input logic [35:0] d);
        dif.diag_strobe = 1'b1; dif.diag_func = f; dif.diag_data = d;
        @(posedge clk); #1;
        dif.diag_strobe = 1'b0; dif.diag_func = 7'o0; dif.diag_data = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic mid_reset(input string n);
        #2 reset = 1'b1;
        #1 chk(n, {dif.busy, dif.dram_addr, dif.dram_din, dif.dram_we, dif.dram_en,
                   dif.rd_data, dif.rd_valid, dif.par_err, dif.overrun}, 64'h0);
        @(posedge clk); #1 reset = 1'b0;
    endtask

    initial begin
        int nmis;
        dif.diag_strobe = 1'b0; dif.diag_func = '0; dif.diag_data = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        idle(2);
        chk("reset rd_data", dif.rd_data, 15'h0);
        // single write and readback
        str(7'o50, 36'o254);
        str(7'o51, 36'o35);
        str(7'o52, 36'o247);
        str(7'o53, 36'o0);
        chk("wr c1 busy", dif.busy, 1'b1);
        chk("wr c1 we", dif.dram_we, 1'b1);
        idle(1);
        chk("wr c2 busy", dif.busy, 1'b0);
        chk("ram[254]", ram[172], 15'h3AA7);
        str(7'o50, 36'o254);
        str(7'o54, 36'o0);
        chk("rd c1 busy", dif.busy, 1'b1);
        chk("rd c1 en", dif.dram_en, 1'b1);
        idle(1);
        chk("rd c2 rd_valid", dif.rd_valid, 1'b0);
        idle(1);
        chk("rd c3 rd_valid", dif.rd_valid, 1'b1);
        chk("rd c3 rd_data", dif.rd_data, 15'h3AA7);
        chk("rd c3 par_err", dif.par_err, 1'b0);
        chk("rd c3 busy", dif.busy, 1'b0);
        idle(2);
        // async reset mid-cycle clears everything including staging
        mid_reset("reset outputs");
        str(7'o53, 36'o0);
        idle(2);
        chk("post-reset word", ram[0], 15'h0100);
        // wraparound
        str(7'o51, 36'o77);
        str(7'o52, 36'o0);
        str(7'o50, 36'd511);
        wr_log.delete();
        str(7'o53, 36'o0); idle(1);
        str(7'o53, 36'o0); idle(1);
        str(7'o53, 36'o0); idle(1);
        chk("wrap count", wr_log.size(), 3);
        chk("wrap addr0", wr_log[0], 511);
        chk("wrap addr1", wr_log[1], 0);
        chk("wrap addr2", wr_log[2], 1);
        chk("ram[511]", ram[511], 15'h7F00);
        chk("ram[0]", ram[0], 15'h7F00);
        // overrun: strobe during READ is dropped
        str(7'o50, 36'd10);
        wr_log.delete();
        str(7'o54, 36'o0);
        str(7'o50, 36'd300);
        idle(3);
        chk("overrun set", dif.overrun, 1'b1);
        str(7'o53, 36'o0); idle(1);
        chk("overrun addr kept", wr_log[0], 11);
        str(7'o55, 36'o0);
        chk("overrun cleared", dif.overrun, 1'b0);
        idle(1);
        // parity error stays sticky across a good read
        str(7'o50, 36'o254);
        ram_bad = 1'b1;
        str(7'o54, 36'o0);
        idle(3);
        ram_bad = 1'b0;
        chk("bad read data", dif.rd_data, 15'h0);
        chk("bad read par_err", dif.par_err, 1'b1);
        str(7'o50, 36'o254);
        str(7'o54, 36'o0);
        idle(3);
        chk("good read data", dif.rd_data, 15'h3AA7);
        chk("par_err sticky", dif.par_err, 1'b1);
        str(7'o55, 36'o0);
        chk("par_err cleared", dif.par_err, 1'b0);
        idle(1);
        // reset in cycle 1 of a WRITE aborts it
        str(7'o50, 36'd100);
        str(7'o53, 36'o0);
        chk("abort we before", dif.dram_we, 1'b1);
        mid_reset("abort outputs");
        chk("abort ram[100]", ram[100], 15'h7FFF);
        idle(2);
        chk("abort idle", dif.busy, 1'b0);
        nmis = 0;
        for (int i = 0; i < 512; i++) if (ram[i] !== mem_e[i]) nmis++;
        chk("ram scoreboard", nmis, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
